// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud constants
// used by the transmit path (and later the receive path).
package uart_pkg;

    localparam int UART_B    = 8;
    localparam int UART_DVSR = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// DVSR-modulo bit-period counter; last_tick marks the final cycle of a bit.
// Held at zero while clr is high so a new frame always starts on a full bit.
module uart_baud_cnt #(
    parameter int DVSR = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic last_tick
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

    logic [CW-1:0] cnt;

    assign last_tick = (cnt == CW'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (last_tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and sends each word as a UART frame.
// Define PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int B    = UART_B,
    parameter int DVSR = UART_DVSR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         empty,
    input  logic [B-1:0] r_data,
    output logic         rd,
    output logic         tx,
    output logic         busy
);

    localparam int IW = (B > 1) ? $clog2(B) : 1;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
`ifdef PARITY_EN
    localparam logic [2:0] PARITY = ST_PARITY;
`endif
    localparam logic [2:0] STOP   = ST_STOP;

    logic [2:0]    state;
    logic [B-1:0]  shreg;
    logic [IW-1:0] bidx;
    logic          last_tick;
    logic          cnt_clr;
`ifdef PARITY_EN
    logic          par;
`endif

    assign rd      = (state == IDLE) && !empty && !reset;
    assign cnt_clr = (state == IDLE);

    uart_baud_cnt #(.DVSR(DVSR)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .last_tick (last_tick)
    );

    // tx is registered, so each transition loads the level of the bit that follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            shreg <= '0;
            bidx  <= '0;
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd) begin
                        shreg <= r_data;
                        bidx  <= '0;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
`ifdef PARITY_EN
                        par   <= ^r_data;
`endif
                    end
                end
                START: begin
                    if (last_tick) begin
                        state <= DATA;
                        tx    <= shreg[0];
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        shreg <= shreg >> 1;
                        bidx  <= bidx + IW'(1);
                        if (bidx == IW'(B - 1)) begin
`ifdef PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shreg[1];
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (B=8, DVSR=4) with a queue-backed FWFT FIFO
// model and a frame-level reference model. Honours PARITY_EN like the design.
module tb_fifo_uart_tx;

    localparam int B    = 8;
    localparam int DVSR = 4;
`ifdef PARITY_EN
    localparam int NBITS = B + 3;
`else
    localparam int NBITS = B + 2;
`endif
    localparam int FL   = NBITS * DVSR;
    localparam int MAXN = 512;

    logic         clk = 1'b0;
    logic         reset;
    logic         empty;
    logic [B-1:0] r_data;
    logic         rd, tx, busy;

    logic [B-1:0] fifo_q[$];
    logic [B-1:0] exp_bytes[$];

    logic rec_rd[MAXN], rec_tx[MAXN], rec_busy[MAXN];
    logic exp_rd[MAXN], exp_tx[MAXN], exp_busy[MAXN];
    logic s_rd, s_tx, s_busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  pat_np;  // transmit order from bit 0: start, D0..D7, stop
        logic [10:0] pat_p;   // start, D0..D7, parity, stop
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    fifo_uart_tx #(.B(B), .DVSR(DVSR)) dut (
        .clk    (clk),
        .reset  (reset),
        .empty  (empty),
        .r_data (r_data),
        .rd     (rd),
        .tx     (tx),
        .busy   (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        empty  = (fifo_q.size() == 0);
        r_data = empty ? B'($urandom) : fifo_q[0];
    endtask

    // One clock cycle: sample mid-cycle, then let the FIFO model react to rd.
    task automatic step();
        @(negedge clk);
        s_rd = rd; s_tx = tx; s_busy = busy;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive();
        for (int i = 0; i < n; i++) begin
            step();
            chk("reset rd", 32'(s_rd), 0);
            if (i >= 1) begin
                chk("reset tx", 32'(s_tx), 1);
                chk("reset busy", 32'(s_busy), 0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic run_rec(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rec_rd[i] = s_rd; rec_tx[i] = s_tx; rec_busy[i] = s_busy;
        end
    endtask

    // Frame-level model: pops every FL+1 cycles starting at cycle 0.
    task automatic model_fill(input int n);
        for (int c = 0; c < n; c++) begin
            int k, off, b;
            k = c / (FL + 1);
            off = c % (FL + 1);
            exp_rd[c] = 1'b0; exp_tx[c] = 1'b1; exp_busy[c] = 1'b0;
            if (k < exp_bytes.size()) begin
                if (off == 0) exp_rd[c] = 1'b1;
                else begin
                    exp_busy[c] = 1'b1;
                    b = (off - 1) / DVSR;
                    if (b == 0) exp_tx[c] = 1'b0;
                    else if (b <= B) exp_tx[c] = exp_bytes[k][b-1];
                    else if (b == B + 1 && NBITS == B + 3) exp_tx[c] = ^exp_bytes[k];
                    else exp_tx[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp_trace(input string name, input int n);
        int m_rd, m_tx, m_bz, first;
        m_rd = 0; m_tx = 0; m_bz = 0; first = -1;
        for (int c = 0; c < n; c++) begin
            if (rec_rd[c] !== exp_rd[c]) m_rd++;
            if (rec_tx[c] !== exp_tx[c]) m_tx++;
            if (rec_busy[c] !== exp_busy[c]) m_bz++;
            if (first < 0 && (rec_rd[c] !== exp_rd[c] || rec_tx[c] !== exp_tx[c] ||
                              rec_busy[c] !== exp_busy[c])) first = c;
        end
        if (first >= 0)
            $display("note %s: first divergence at cycle %0d rd=%b/%b tx=%b/%b busy=%b/%b",
                     name, first, rec_rd[first], exp_rd[first], rec_tx[first], exp_tx[first],
                     rec_busy[first], exp_busy[first]);
        chk({name, " rd mismatched cycles"}, 32'(m_rd), 0);
        chk({name, " tx mismatched cycles"}, 32'(m_tx), 0);
        chk({name, " busy mismatched cycles"}, 32'(m_bz), 0);
    endtask

    initial begin
        int n, cnt, p0, p1;
        logic [10:0] pat;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0};
        vecs[2] = '{8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};
        vecs[4] = '{8'h80, 10'b1_10000000_0, 11'b1_1_10000000_0};

        // Reset with a word waiting: no pop until reset falls, then pop at once.
        fifo_q.push_back(8'h11);
        do_reset(4);
        step();
        chk("first rd after reset", 32'(s_rd), 1);

        // Table vectors: single word per run against hand-written frame patterns.
        foreach (vecs[v]) begin
            fifo_q.delete();
            fifo_q.push_back(vecs[v].data);
            do_reset(2);
`ifdef PARITY_EN
            pat = vecs[v].pat_p;
`else
            pat = {1'b1, vecs[v].pat_np};
`endif
            n = FL + 6;
            run_rec(n);
            for (int c = 0; c < n; c++) begin
                exp_rd[c]   = (c == 0);
                exp_busy[c] = (c >= 1 && c <= FL);
                exp_tx[c]   = (c >= 1 && c <= FL) ? pat[(c-1)/DVSR] : 1'b1;
            end
            cmp_trace($sformatf("vec%0d", v), n);
            cnt = 0;
            for (int c = 0; c < n; c++) if (rec_busy[c] === 1'b1) cnt++;
            chk($sformatf("vec%0d busy cycles", v), 32'(cnt), 32'(FL));
            cnt = 0;
            for (int c = 0; c < n; c++) if (rec_rd[c] === 1'b1) cnt++;
            chk($sformatf("vec%0d rd pulses", v), 32'(cnt), 1);
        end

        // 0x00 then 0xFF back to back: pop spacing and the all-ones data window.
        fifo_q.delete();
        exp_bytes.delete();
        fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'hFF);
        do_reset(2);
        n = 2 * (FL + 1) + 4;
        run_rec(n);
        model_fill(n);
        cmp_trace("b2b", n);
        p0 = -1; p1 = -1;
        for (int c = 0; c < n; c++)
            if (rec_rd[c] === 1'b1) begin
                if (p0 < 0) p0 = c; else if (p1 < 0) p1 = c;
            end
        chk("b2b pop-to-pop", 32'(p1 - p0), 32'(FL + 1));
        cnt = 0;
        for (int c = 0; c < B * DVSR; c++)
            if (rec_tx[(FL + 1) + 1 + DVSR + c] === 1'b1) cnt++;
        chk("b2b second data ones", 32'(cnt), 32'(B * DVSR));

        // Reset during DATA bit 3 of 0x3C: frame dropped, next word pops after reset.
        fifo_q.delete();
        fifo_q.push_back(8'h3C); fifo_q.push_back(8'h55);
        do_reset(2);
        run_rec(1 + DVSR * 4 + 2);
        chk("midreset tx in bit3", 32'(rec_tx[DVSR * 4 + 2]), 1);  // bit3 of 0x3C
        do_reset(3);
        chk("midreset queue after reset", 32'(fifo_q.size()), 1);
        exp_bytes.delete();
        exp_bytes.push_back(8'h55);
        n = FL + 4;
        run_rec(n);
        model_fill(n);
        cmp_trace("after midreset", n);
        chk("midreset queue drained", 32'(fifo_q.size()), 0);

        // Randomized streams against the frame model.
        for (int r = 0; r < 4; r++) begin
            int nb;
            nb = $urandom_range(2, 5);
            fifo_q.delete();
            exp_bytes.delete();
            for (int i = 0; i < nb; i++) begin
                logic [7:0] d;
                d = 8'($urandom);
                fifo_q.push_back(d);
                exp_bytes.push_back(d);
            end
            do_reset(2);
            n = nb * (FL + 1) + 5;
            run_rec(n);
            model_fill(n);
            cmp_trace($sformatf("rand%0d", r), n);
        end

        // Long empty stretch: line idles high, no pops.
        fifo_q.delete();
        do_reset(2);
        begin
            int bad_rd, bad_tx, bad_bz;
            bad_rd = 0; bad_tx = 0; bad_bz = 0;
            for (int i = 0; i < 1000; i++) begin
                step();
                if (s_rd !== 1'b0) bad_rd++;
                if (s_tx !== 1'b1) bad_tx++;
                if (s_busy !== 1'b0) bad_bz++;
            end
            chk("idle rd cycles", 32'(bad_rd), 0);
            chk("idle tx-low cycles", 32'(bad_tx), 0);
            chk("idle busy cycles", 32'(bad_bz), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
